// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enable dual-port RAM: clear-engine state
// encoding, default geometry and the byte-lane merge used by both the write
// path and the read/write collision bypass.
package ram_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int BYTE_W     = 8;

  // Clear engine state. CLEAR is the reset state so the array is always
  // scrubbed before the ports are opened.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Byte-lane merge: returns the new byte when its enable is set, otherwise
  // keeps the old byte. Callers apply it lane by lane across a word, which
  // keeps it independent of DATA_W.
  function automatic logic [BYTE_W-1:0] merge_be(input logic [BYTE_W-1:0] old_b,
                                                 input logic [BYTE_W-1:0] new_b,
                                                 input logic              be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/ram_clr_fsm.sv
// Clear engine: walks every address once after reset or on clr_req, writing
// zero, and tells the top when the user ports may be serviced.
module ram_clr_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              port_ok,
  output logic              busy,
  output clr_state_e        state_o
);

  clr_state_e        state_q,   state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              busy_q,    busy_d;

  // Next-state logic. The ports are only opened in IDLE on a cycle without a
  // clear request, so a request drops any same-cycle access.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy_q;
    clr_we    = 1'b0;
    clr_addr  = clr_ptr_q;
    port_ok   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        // Last address written this cycle: leave before the pointer wraps.
        if (clr_ptr_q == '1) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
          busy_d    = 1'b1;
        end else begin
          port_ok = 1'b1;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_ptr_d = '0;
        busy_d    = 1'b1;
      end
    endcase
  end

  // State register; reset restarts the clear from address 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign state_o = state_q;

endmodule

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte-enable writes, registered read with a valid
// strobe, write-first collision bypass and a hardware clear engine.
//
// Handshake: a request (wena or rena) is accepted on a rising edge when
// ena=1, busy=0 and clr_req=0; there is no back-pressure. An accepted read
// returns data on rdata with rvalid high for exactly the following cycle.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     wena,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/BYTE_W-1:0] wbe,
  input  logic                     rena,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic                     clr_req,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid,
  output logic                     busy,
  output clr_state_e               dbg_state
);

  // DATA_W must be a multiple of 8; each wbe bit covers one byte lane.
  localparam int BE_W  = DATA_W / BYTE_W;
  localparam int DEPTH = 2 ** ADDR_W;

  // Storage has no reset so it can map onto distributed/block RAM; the
  // clear engine is the only way it is zeroed.
  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              port_ok;

  logic              wr_fire;
  logic              rd_fire;
  logic              collide;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_word;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  ram_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .port_ok  (port_ok),
    .busy     (busy),
    .state_o  (dbg_state)
  );

  assign wr_fire = ena && wena && port_ok;
  assign rd_fire = ena && rena && port_ok;
  assign collide = wr_fire && (waddr == raddr);

  // Write-port mux: the clear engine owns the port while busy (port_ok is
  // low then, so the two sources never compete).
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_addr;
    wr_word = '0;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_word = '0;
    end else if (wr_fire) begin
      wr_en   = 1'b1;
      wr_addr = waddr;
      for (int b = 0; b < BE_W; b++) begin
        wr_word[b*BYTE_W +: BYTE_W] = merge_be(mem[waddr][b*BYTE_W +: BYTE_W],
                                               wdata[b*BYTE_W +: BYTE_W],
                                               wbe[b]);
      end
    end
  end

  // Array write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  // Read datapath: on a same-address collision the enabled bytes come from
  // wdata so the reader sees the post-write word (write-first).
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      if (collide) begin
        for (int b = 0; b < BE_W; b++) begin
          rdata_d[b*BYTE_W +: BYTE_W] = merge_be(mem[raddr][b*BYTE_W +: BYTE_W],
                                                 wdata[b*BYTE_W +: BYTE_W],
                                                 wbe[b]);
        end
      end else begin
        rdata_d = mem[raddr];
      end
    end
  end

  // Read output register; rdata holds between accepted reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be: dut_a uses the default 32x32 geometry, dut_b the
// 16-bit x 8-word variant. Both share one clock and are stepped together.
module tb_ram_dp_be;
  import ram_pkg::*;

  // ---------------- clock ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus (index 0 = dut_a, 1 = dut_b) ----------------
  logic        in_rst_n [2];
  logic        in_ena   [2];
  logic        in_wena  [2];
  logic [4:0]  in_waddr [2];
  logic [31:0] in_wdata [2];
  logic [3:0]  in_wbe   [2];
  logic        in_rena  [2];
  logic [4:0]  in_raddr [2];
  logic        in_clr   [2];

  logic [31:0] a_rdata;
  logic        a_rvalid, a_busy;
  clr_state_e  a_state;

  logic [2:0]  b_waddr, b_raddr;
  logic [15:0] b_wdata;
  logic [1:0]  b_wbe;
  logic [15:0] b_rdata;
  logic        b_rvalid, b_busy;
  clr_state_e  b_state;

  assign b_waddr = in_waddr[1][2:0];
  assign b_raddr = in_raddr[1][2:0];
  assign b_wdata = in_wdata[1][15:0];
  assign b_wbe   = in_wbe[1][1:0];

  ram_dp_be #(.DATA_W(32), .ADDR_W(5)) dut_a (
    .clk (clk), .rst_n (in_rst_n[0]), .ena (in_ena[0]), .wena (in_wena[0]),
    .waddr (in_waddr[0]), .wdata (in_wdata[0]), .wbe (in_wbe[0]),
    .rena (in_rena[0]), .raddr (in_raddr[0]), .clr_req (in_clr[0]),
    .rdata (a_rdata), .rvalid (a_rvalid), .busy (a_busy), .dbg_state (a_state)
  );

  ram_dp_be #(.DATA_W(16), .ADDR_W(3)) dut_b (
    .clk (clk), .rst_n (in_rst_n[1]), .ena (in_ena[1]), .wena (in_wena[1]),
    .waddr (b_waddr), .wdata (b_wdata), .wbe (b_wbe),
    .rena (in_rena[1]), .raddr (b_raddr), .clr_req (in_clr[1]),
    .rdata (b_rdata), .rvalid (b_rvalid), .busy (b_busy), .dbg_state (b_state)
  );

  // ---------------- scoreboard and reference model ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q_a [$];
  logic [31:0] exp_q_b [$];
  logic [31:0] mdl_mem   [2][32];
  int          mdl_cnt   [2];
  int          mdl_ptr   [2];
  logic [31:0] mdl_rdata [2];
  logic        mdl_rvalid[2];

  function automatic int dep(input int s);
    return (s == 1) ? 8 : 32;
  endfunction

  function automatic int nbytes(input int s);
    return (s == 1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] obs_rdata(input int s);
    return (s == 1) ? {16'h0, b_rdata} : a_rdata;
  endfunction

  function automatic logic obs_rvalid(input int s);
    return (s == 1) ? b_rvalid : a_rvalid;
  endfunction

  function automatic logic obs_busy(input int s);
    return (s == 1) ? b_busy : a_busy;
  endfunction

  function automatic clr_state_e obs_state(input int s);
    return (s == 1) ? b_state : a_state;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one DUT at one rising edge.
  task automatic model_edge(input int s);
    int wa, ra;
    wa = int'(in_waddr[s]) % dep(s);
    ra = int'(in_raddr[s]) % dep(s);
    mdl_rvalid[s] = 1'b0;
    if (!in_rst_n[s]) begin
      mdl_cnt[s]   = dep(s);
      mdl_ptr[s]   = 0;
      mdl_rdata[s] = 32'h0;
    end else if (mdl_cnt[s] > 0) begin
      mdl_mem[s][mdl_ptr[s]] = 32'h0;
      mdl_ptr[s]++;
      mdl_cnt[s]--;
    end else if (in_clr[s]) begin
      mdl_cnt[s] = dep(s);
      mdl_ptr[s] = 0;
    end else if (in_ena[s]) begin
      if (in_wena[s]) begin
        for (int b = 0; b < nbytes(s); b++) begin
          if (in_wbe[s][b]) mdl_mem[s][wa][b*8 +: 8] = in_wdata[s][b*8 +: 8];
        end
      end
      if (in_rena[s]) begin
        mdl_rdata[s]  = mdl_mem[s][ra];
        mdl_rvalid[s] = 1'b1;
        if (s == 1) exp_q_b.push_back(mdl_rdata[s]);
        else        exp_q_a.push_back(mdl_rdata[s]);
      end
    end
  endtask

  // Compare one DUT's outputs against the model after an edge.
  task automatic score(input int s);
    string       p;
    logic [31:0] exp_d;
    p = (s == 1) ? "b" : "a";
    check_eq($sformatf("%s_busy", p), 32'(obs_busy(s)), 32'(mdl_cnt[s] > 0));
    check_eq($sformatf("%s_state", p), 32'(obs_state(s)),
             32'((mdl_cnt[s] > 0) ? ST_CLEAR : ST_IDLE));
    check_eq($sformatf("%s_rvalid", p), 32'(obs_rvalid(s)), 32'(mdl_rvalid[s]));
    if (obs_rvalid(s)) begin
      if (s == 1) begin
        check_eq("b_sb_pending", 32'(exp_q_b.size() > 0), 32'h1);
        if (exp_q_b.size() > 0) begin
          exp_d = exp_q_b.pop_front();
          check_eq("b_sb_rdata", obs_rdata(s), exp_d);
        end
      end else begin
        check_eq("a_sb_pending", 32'(exp_q_a.size() > 0), 32'h1);
        if (exp_q_a.size() > 0) begin
          exp_d = exp_q_a.pop_front();
          check_eq("a_sb_rdata", obs_rdata(s), exp_d);
        end
      end
    end else begin
      check_eq($sformatf("%s_rdata_hold", p), obs_rdata(s), mdl_rdata[s]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_ops();
    for (int s = 0; s < 2; s++) begin
      in_ena[s]   = 1'b1;
      in_wena[s]  = 1'b0;
      in_waddr[s] = '0;
      in_wdata[s] = '0;
      in_wbe[s]   = '0;
      in_rena[s]  = 1'b0;
      in_raddr[s] = '0;
      in_clr[s]   = 1'b0;
    end
  endtask

  // One clock: model both DUTs at the edge, score on the falling edge, then
  // return the request lines to idle for the caller to set up the next cycle.
  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    score(0);
    score(1);
    clear_ops();
  endtask

  task automatic wr(input int s, input int a, input logic [31:0] d, input logic [3:0] be);
    in_wena[s]  = 1'b1;
    in_waddr[s] = 5'(a);
    in_wdata[s] = d;
    in_wbe[s]   = be;
  endtask

  task automatic rd(input int s, input int a);
    in_rena[s]  = 1'b1;
    in_raddr[s] = 5'(a);
  endtask

  // Steps until dut s drops busy; n is the number of edges taken, -1 on timeout.
  task automatic measure_clear(input int s, output int n);
    n = -1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (!obs_busy(s)) begin
        n = k;
        break;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n_a, n_b;
    for (int s = 0; s < 2; s++) begin
      in_rst_n[s]   = 1'b0;
      mdl_cnt[s]    = 0;
      mdl_ptr[s]    = 0;
      mdl_rdata[s]  = 'x;
      mdl_rvalid[s] = 1'b0;
      for (int i = 0; i < 32; i++) mdl_mem[s][i] = 'x;
    end
    clear_ops();
    @(negedge clk);

    // Test 1: reset for two cycles, clear length, then all-zero reads.
    step();
    step();
    check_eq("t1_rst_rdata_a", a_rdata, 32'h0);
    check_eq("t1_rst_rvalid_a", 32'(a_rvalid), 32'h0);
    in_rst_n[0] = 1'b1;
    in_rst_n[1] = 1'b1;
    n_a = -1;
    n_b = -1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (n_a < 0 && !a_busy) n_a = k;
      if (n_b < 0 && !b_busy) n_b = k;
      if (n_a >= 0 && n_b >= 0) break;
    end
    check_eq("t1_clear_len_a", 32'(n_a), 32'd32);
    check_eq("t1_clear_len_b", 32'(n_b), 32'd8);
    for (int i = 0; i < 32; i++) begin
      rd(0, i);
      if (i < 8) rd(1, i);
      step();
      check_eq("t1_rd_zero_a", a_rdata, 32'h0);
      check_eq("t1_rvalid_a", 32'(a_rvalid), 32'h1);
    end
    step();

    // Test 2: byte-enable merge, both widths.
    wr(0, 3, 32'hAABBCCDD, 4'b1111);
    wr(1, 3, 32'h0000CCDD, 4'b0011);
    step();
    wr(0, 3, 32'h11223344, 4'b0101);
    wr(1, 3, 32'h00003344, 4'b0001);
    step();
    rd(0, 3);
    rd(1, 3);
    step();
    check_eq("t2_merge_a", a_rdata, 32'hAA22CC44);
    check_eq("t2_merge_b", {16'h0, b_rdata}, 32'h0000CC44);

    // Test 3: same-cycle write/read to one address returns the merged word.
    wr(0, 7, 32'hFFFFFFFF, 4'b0011);
    rd(0, 7);
    wr(1, 5, 32'h0000FFFF, 4'b0001);
    rd(1, 5);
    step();
    check_eq("t3_bypass_a", a_rdata, 32'h0000FFFF);
    check_eq("t3_bypass_rv_a", 32'(a_rvalid), 32'h1);
    check_eq("t3_bypass_b", {16'h0, b_rdata}, 32'h000000FF);
    // Different addresses in one cycle: independent.
    wr(0, 9, 32'h12345678, 4'b1111);
    rd(0, 3);
    step();
    check_eq("t3_indep_a", a_rdata, 32'hAA22CC44);
    rd(0, 9);
    step();
    check_eq("t3_indep_wr_a", a_rdata, 32'h12345678);

    // Test 4: ena=0 ignores both ports; no read leaves rdata held.
    in_ena[0] = 1'b0;
    wr(0, 1, 32'h00000005, 4'b1111);
    rd(0, 2);
    step();
    check_eq("t4_ena0_rvalid", 32'(a_rvalid), 32'h0);
    rd(0, 1);
    step();
    check_eq("t4_no_write", a_rdata, 32'h0);
    step();
    check_eq("t4_idle_rvalid", 32'(a_rvalid), 32'h0);
    check_eq("t4_idle_hold", a_rdata, 32'h0);

    // Test 5a: fill, clear request with a same-cycle write and read.
    for (int i = 0; i < 32; i++) begin
      wr(0, i, 32'hDEADBEEF, 4'b1111);
      step();
    end
    in_clr[0] = 1'b1;
    wr(0, 4, 32'h0BADF00D, 4'b1111);
    rd(0, 5);
    step();
    check_eq("t5_req_busy", 32'(a_busy), 32'h1);
    check_eq("t5_req_rvalid", 32'(a_rvalid), 32'h0);
    measure_clear(0, n_a);
    check_eq("t5_clr_len", 32'(n_a), 32'd32);
    rd(0, 4);
    step();
    check_eq("t5_dropped_wr", a_rdata, 32'h0);

    // Test 5b: refill, clear, reset at clear cycle 10, restart is full length.
    for (int i = 0; i < 32; i++) begin
      wr(0, i, 32'hDEADBEEF, 4'b1111);
      step();
    end
    in_clr[0] = 1'b1;
    step();
    for (int k = 0; k < 10; k++) step();
    in_rst_n[0] = 1'b0;
    step();
    in_rst_n[0] = 1'b1;
    n_a = -1;
    for (int k = 1; k <= 100; k++) begin
      if (k == 5) in_clr[0] = 1'b1;   // request while busy: ignored
      step();
      if (!a_busy) begin
        n_a = k;
        break;
      end
    end
    check_eq("t5_rst_clr_len", 32'(n_a), 32'd32);
    for (int i = 0; i < 32; i++) begin
      rd(0, i);
      step();
      check_eq("t5_rd_zero", a_rdata, 32'h0);
    end
    step();

    check_eq("a_sb_drain", 32'(exp_q_a.size()), 32'h0);
    check_eq("b_sb_drain", 32'(exp_q_b.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
